serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits, legal range 1..32.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, the reset: synchronous, active-low.
REQ-004 The block SHALL have port start, input, 1, a request to add; sampled on a rising edge.
REQ-005 The block SHALL have port a, input, WIDTH, operand A, captured when start is accepted.
REQ-006 The block SHALL have port b, input, WIDTH, operand B, captured when start is accepted.
REQ-007 The block SHALL have port cin, input, 1, carry-in, captured when start is accepted.
REQ-008 The block SHALL have port busy, output, 1, high while state is RUN.
REQ-009 The block SHALL have port done, output, 1, a one-cycle completion pulse, high while state is DONE.
REQ-010 The block SHALL have port sum, output, WIDTH, the registered result.
REQ-011 The block SHALL have port cout, output, 1, the registered carry-out.
REQ-012 The block SHALL have port ovf, output, 1, the registered signed-overflow flag; this port exists only when SERIAL_ADDER_OVF_EN is defined.

Function
REQ-013 The block SHALL implement a three-state machine with states IDLE, RUN and DONE.
REQ-014 In IDLE, start=1 at an edge SHALL capture a, b and cin into shift registers, clear the bit counter to 0, and move to RUN.
REQ-015 In RUN, each edge SHALL process exactly one bit, LSB first, through a single full-adder cell (one half-adder pair plus OR), using the carry register as carry-in.
REQ-016 The carry register SHALL be loaded with cin on accept and with the cell carry-out on each RUN edge.
REQ-017 On the RUN edge that processes bit WIDTH-1, the block SHALL load sum, cout (and ovf) with the final values and move to DONE.
REQ-018 The fixed latency SHALL be: start sampled at edge 0, done high in the cycle following edge WIDTH, for exactly one cycle.
REQ-019 In DONE, start=1 SHALL be accepted back-to-back, behaving as in IDLE and going directly to RUN; otherwise the block SHALL return to IDLE.
REQ-020 start asserted while in RUN SHALL be ignored, with no effect on the operands, counter or outputs.
REQ-021 sum and cout SHALL change only on the completion edge and hold their values through IDLE and subsequent RUN periods until the next completion.
REQ-022 The result SHALL equal {cout,sum} = a + b + cin, computed modulo 2^(WIDTH+1), with operands as captured at accept.
REQ-023 Operand inputs SHALL be don't-care outside the accept edge.
REQ-024 With WIDTH=1, RUN SHALL last one edge and the block SHALL behave as a registered full adder with 2-edge done latency.

Reset
REQ-025 rst_n=0 at an edge SHALL force state IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, counter=0 and carry=0, taking priority over start.
REQ-026 A reset during RUN SHALL abort the operation; no done pulse SHALL follow, and a start on the first edge with rst_n=1 SHALL be accepted normally.

Configuration
REQ-027 When SERIAL_ADDER_OVF_EN is defined, ovf SHALL be loaded on completion with the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1 (two's-complement overflow).
REQ-028 When SERIAL_ADDER_OVF_EN is undefined, the ovf port and its logic SHALL be absent, with all other behaviour identical.

Verification
REQ-029 The bench SHALL cover a WIDTH=1 exhaustive test: all 8 combinations of a, b, cin -> {cout,sum} = a+b+cin; with cin=0 this matches the half-adder truth table (1+1 -> sum 0, cout 1).
REQ-030 The bench SHALL cover WIDTH=8, a=0xFF, b=0x01, cin=0 -> done at the cycle after edge 8, sum=0x00, cout=1, ovf=0.
REQ-031 The bench SHALL cover WIDTH=8, a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1; then a=0x7F, b=0x01, cin=0 issued back-to-back in DONE -> sum=0x80, cout=0, ovf=1 (when the macro is defined).
REQ-032 The bench SHALL cover start pulsed at RUN edge 3 with different operands -> ignored, and the first result is unchanged.
REQ-033 The bench SHALL cover rst_n=0 for one edge at RUN edge 4 -> no done, all outputs 0; the next start completes correctly with 8-edge latency.
REQ-034 The bench SHALL cover a randomized check of 1000 operations at WIDTH=8 and at WIDTH=13 -> every result matches the reference sum, and busy is high for exactly WIDTH cycles per operation.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell, LSB first, WIDTH edges per operation.
// Define SERIAL_ADDER_OVF_EN to add the registered two's-complement overflow output ovf.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   logic ha1_s, ha1_c, ha2_s, ha2_c, cell_co;

   // Full-adder cell built from two half adders and an OR on the current LSBs.
   always_comb begin
      ha1_s   = a_q[0] ^ b_q[0];
      ha1_c   = a_q[0] & b_q[0];
      ha2_s   = ha1_s ^ carry_q;
      ha2_c   = ha1_s & carry_q;
      cell_co = ha1_c | ha2_c;
   end

   // Next-state logic for the FSM, operand shifters, counter and result registers.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_d   = ovf_q;
`endif
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               carry_d = cin;
               cnt_d   = '0;
               state_d = S_RUN;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            a_d               = a_q >> 1;
            b_d               = b_q >> 1;
            acc_d             = acc_q >> 1;
            acc_d[WIDTH-1]    = ha2_s;
            carry_d           = cell_co;
            cnt_d             = cnt_q + CNT_ONE;
            if (cnt_q == CNT_LAST) begin
               sum_d   = acc_d;
               cout_d  = cell_co;
`ifdef SERIAL_ADDER_OVF_EN
               // Carry into the MSB differs from carry out of it on signed overflow.
               ovf_d   = carry_q ^ cell_co;
`endif
               state_d = S_DONE;
            end else begin
               state_d = S_RUN;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign busy = (state_q == S_RUN);
   assign done = (state_q == S_DONE);
   assign sum  = sum_q;
   assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
   assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed and randomized self-checking bench for serial_adder at WIDTH 1, 8 and 13.
module tb_serial_adder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start1, start8, start13;
   logic [31:0] a_drv, b_drv;
   logic        cin_drv;

   logic        busy1, done1, cout1;
   logic [0:0]  sum1;
   logic        busy8, done8, cout8;
   logic [7:0]  sum8;
   logic        busy13, done13, cout13;
   logic [12:0] sum13;
`ifdef SERIAL_ADDER_OVF_EN
   logic        ovf1, ovf8, ovf13;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(1)) u_w1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .a(a_drv[0:0]), .b(b_drv[0:0]), .cin(cin_drv),
      .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
`ifdef SERIAL_ADDER_OVF_EN
      , .ovf(ovf1)
`endif
   );

   serial_adder #(.WIDTH(8)) u_w8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .a(a_drv[7:0]), .b(b_drv[7:0]), .cin(cin_drv),
      .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
`ifdef SERIAL_ADDER_OVF_EN
      , .ovf(ovf8)
`endif
   );

   serial_adder #(.WIDTH(13)) u_w13 (
      .clk(clk), .rst_n(rst_n), .start(start13), .a(a_drv[12:0]), .b(b_drv[12:0]), .cin(cin_drv),
      .busy(busy13), .done(done13), .sum(sum13), .cout(cout13)
`ifdef SERIAL_ADDER_OVF_EN
      , .ovf(ovf13)
`endif
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_start(input int w, input logic v);
      case (w)
         1:       start1  = v;
         8:       start8  = v;
         default: start13 = v;
      endcase
   endtask

   task automatic get(input int w, output logic bz, output logic dn, output logic [31:0] s,
                      output logic co, output logic ov);
      s  = '0;
      ov = 1'b0;
      case (w)
         1: begin
            bz = busy1; dn = done1; s[0:0] = sum1; co = cout1;
`ifdef SERIAL_ADDER_OVF_EN
            ov = ovf1;
`endif
         end
         8: begin
            bz = busy8; dn = done8; s[7:0] = sum8; co = cout8;
`ifdef SERIAL_ADDER_OVF_EN
            ov = ovf8;
`endif
         end
         default: begin
            bz = busy13; dn = done13; s[12:0] = sum13; co = cout13;
`ifdef SERIAL_ADDER_OVF_EN
            ov = ovf13;
`endif
         end
      endcase
   endtask

   // Issue one operation (called at posedge+1), optionally pulsing start at RUN edge 'poke'.
   // Returns in the done cycle, so a following call is a back-to-back start.
   task automatic run_op(input int w, input logic [31:0] av, input logic [31:0] bv, input logic ci,
                         input logic [31:0] es, input logic ec, input logic eo,
                         input int poke, input string nm);
      logic bz, dn, co, ov;
      logic [31:0] s;
      int cyc, busy_cnt;
      logic got;
      a_drv = av; b_drv = bv; cin_drv = ci;
      set_start(w, 1'b1);
      step();
      set_start(w, 1'b0);
      a_drv = ~av; b_drv = ~bv; cin_drv = ~ci;
      cyc = 0; busy_cnt = 0; got = 1'b0;
      while (!got && cyc < w + 4) begin
         get(w, bz, dn, s, co, ov);
         if (dn) begin
            got = 1'b1;
         end else begin
            if (bz) busy_cnt++;
            if (cyc + 1 == poke) begin
               set_start(w, 1'b1);
               a_drv = 32'hFFFF_FFFF; b_drv = 32'hFFFF_FFFF; cin_drv = 1'b1;
            end
            step();
            set_start(w, 1'b0);
            cyc++;
         end
      end
      checks++;
      if (got !== 1'b1 || cyc != w) begin
         errors++;
         $display("FAIL %s latency: done seen=%0b after %0d edges, expected after %0d", nm, got, cyc, w);
      end
      checks++;
      if (busy_cnt != w) begin
         errors++;
         $display("FAIL %s busy: %0d cycles, expected %0d", nm, busy_cnt, w);
      end
      checks++;
      if (s !== es || co !== ec) begin
         errors++;
         $display("FAIL %s result: sum=%h cout=%b, expected sum=%h cout=%b", nm, s, co, es, ec);
      end
`ifdef SERIAL_ADDER_OVF_EN
      checks++;
      if (ov !== eo) begin
         errors++;
         $display("FAIL %s ovf: got %b expected %b", nm, ov, eo);
      end
`else
      if (eo === 1'bx) $display("unexpected X in expected ovf for %s", nm);
`endif
   endtask

   task automatic check_zero(input int w, input string nm);
      logic bz, dn, co, ov;
      logic [31:0] s;
      get(w, bz, dn, s, co, ov);
      checks++;
      if (bz !== 1'b0 || dn !== 1'b0 || s !== 32'h0 || co !== 1'b0 || ov !== 1'b0) begin
         errors++;
         $display("FAIL %s w=%0d: busy=%b done=%b sum=%h cout=%b ovf=%b, expected all 0",
                  nm, w, bz, dn, s, co, ov);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start1 = 1'b1; start8 = 1'b1; start13 = 1'b1;
      a_drv = 32'hFFFF_FFFF; b_drv = 32'hFFFF_FFFF; cin_drv = 1'b1;
      step();
      step();
      check_zero(1, "reset");
      check_zero(8, "reset");
      check_zero(13, "reset");
      start1 = 1'b0; start8 = 1'b0; start13 = 1'b0;
      rst_n = 1'b1;
      step();
      check_zero(8, "reset_idle");
   endtask

   task automatic test_width1();
      // {cout,sum} indexed by {a,b,cin}
      logic [1:0] fa_exp [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
      for (int i = 0; i < 8; i++) begin
         logic [2:0] v;
         logic [1:0] e;
         v = 3'(i);
         e = fa_exp[i];
         run_op(1, {31'd0, v[2]}, {31'd0, v[1]}, v[0], {31'd0, e[0]}, e[1], v[0] ^ e[1],
                0, $sformatf("w1_%0d", i));
         step();
      end
   endtask

   task automatic test_directed();
      run_op(8, 32'hFF, 32'h01, 1'b0, 32'h00, 1'b1, 1'b0, 0, "ff_plus_01");
      step();
      run_op(8, 32'hA5, 32'h5A, 1'b1, 32'h00, 1'b1, 1'b0, 0, "a5_plus_5a_c1");
   endtask

   task automatic test_back_to_back();
      logic bz, dn, co, ov;
      logic [31:0] s;
      run_op(8, 32'h7F, 32'h01, 1'b0, 32'h80, 1'b0, 1'b1, 0, "b2b_7f_plus_01");
      step();
      get(8, bz, dn, s, co, ov);
      checks++;
      if (dn !== 1'b0 || bz !== 1'b0 || s !== 32'h80) begin
         errors++;
         $display("FAIL done_pulse: done=%b busy=%b sum=%h, expected done=0 busy=0 sum=80", dn, bz, s);
      end
   endtask

   task automatic test_ignore_start();
      logic bz, dn, co, ov;
      logic [31:0] s;
      run_op(8, 32'h12, 32'h34, 1'b0, 32'h46, 1'b0, 1'b0, 3, "ignore_start");
      step();
      step();
      get(8, bz, dn, s, co, ov);
      checks++;
      if (dn !== 1'b0 || bz !== 1'b0 || s !== 32'h46 || co !== 1'b0) begin
         errors++;
         $display("FAIL ignore_hold: done=%b busy=%b sum=%h cout=%b, expected 0 0 46 0", dn, bz, s, co);
      end
   endtask

   task automatic test_reset_abort();
      a_drv = 32'h0F; b_drv = 32'h01; cin_drv = 1'b0;
      start8 = 1'b1;
      step();
      start8 = 1'b0;
      for (int k = 1; k < 4; k++) step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check_zero(8, "reset_abort");
      run_op(8, 32'h0F, 32'h01, 1'b0, 32'h10, 1'b0, 1'b0, 0, "after_abort");
      step();
   endtask

   task automatic test_random(input int w);
      logic [31:0] mask, av, bv, es;
      logic [32:0] full;
      logic ci, eo;
      mask = (32'd1 << w) - 32'd1;
      for (int n = 0; n < 1000; n++) begin
         av = $urandom() & mask;
         bv = $urandom() & mask;
         ci = 1'($urandom_range(0, 1));
         full = {1'b0, av} + {1'b0, bv} + {32'd0, ci};
         es = full[31:0] & mask;
         eo = (av[w-1] == bv[w-1]) && (es[w-1] != av[w-1]);
         run_op(w, av, bv, ci, es, full[w], eo, 0, $sformatf("rand_w%0d_%0d", w, n));
         if ($urandom_range(0, 1) == 1) step();
      end
   endtask

   initial begin
      rst_n = 1'b0;
      start1 = 1'b0; start8 = 1'b0; start13 = 1'b0;
      a_drv = '0; b_drv = '0; cin_drv = 1'b0;
      #1;
      test_reset();
      test_width1();
      test_directed();
      test_back_to_back();
      test_ignore_start();
      test_reset_abort();
      test_random(8);
      test_random(13);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
